// File: rtl/rx_bitmap_pkg.sv
// Shared constants and FSM encoding for the RX sequence bitmap controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rx_bitmap_pkg;

    // Default bitmap address width (depth = 2**ADDR_W) and statistics width.
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_CNT_W  = 32;

    // Controller state: sweeping the bitmap to zero, or marking IDs.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/rx_seq_bitmap_ctrl_if.sv
// Bundle of the sequence-ID handshake, result, statistics and bitmap RAM port.
// Latency: n/a (wiring only).
// Backpressure: seq_valid/seq_ready; the ID holder keeps the ID until accepted.
interface rx_seq_bitmap_ctrl_if
    import rx_bitmap_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
);
    logic              seq_valid;
    logic [ADDR_W-1:0] seq_id;
    logic              seq_ready;
    logic              clr_req;
    logic              busy;
    logic              res_valid;
    logic [ADDR_W-1:0] res_seq;
    logic              res_dup;
    logic [CNT_W-1:0]  uniq_cnt;
    logic [CNT_W-1:0]  dup_cnt;
    logic [ADDR_W-1:0] bm_addr;
    logic              bm_din;
    logic              bm_we;
    logic              bm_dout;

    // Controller side.
    modport slave (
        input  seq_valid, seq_id, clr_req, bm_dout,
        output seq_ready, busy, res_valid, res_seq, res_dup,
               uniq_cnt, dup_cnt, bm_addr, bm_din, bm_we
    );

    // Environment side: ID source, result sink and bitmap RAM.
    modport master (
        output seq_valid, seq_id, clr_req, bm_dout,
        input  seq_ready, busy, res_valid, res_seq, res_dup,
               uniq_cnt, dup_cnt, bm_addr, bm_din, bm_we
    );
endinterface

// File: rtl/rx_sat_counter.sv
// Saturating event counter with synchronous clear.
// Latency: count visible the cycle after i_inc.
// Backpressure: none; holds at all-ones once saturated.
module rx_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;

    // Clear has priority over increment; stop at all-ones.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/rx_seq_bitmap_ctrl.sv
// Marks per-frame sequence IDs in a 1-bit bitmap RAM and flags duplicates; owns the clear sweep.
// Latency: result one cycle after accept, 1 ID/cycle; clear sweep takes 2**ADDR_W cycles.
// Backpressure: seq_ready low while sweeping; IDs are not buffered. Stats under RX_SEQ_STATS_EN.
module rx_seq_bitmap_ctrl
    import rx_bitmap_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    rx_seq_bitmap_ctrl_if.slave  bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t            r_state;
    logic [ADDR_W-1:0] r_sweep;
    logic [ADDR_W-1:0] r_last_addr;
    logic              r_seq_ready;
    logic              r_busy;
    logic              r_res_valid;
    logic [ADDR_W-1:0] r_res_seq;

    logic              w_accept;
    logic [ADDR_W-1:0] w_bm_addr;
    logic              w_bm_we;
    logic              w_bm_din;

    // seq_ready is only ever high in RUN, so it alone qualifies the handshake.
    assign w_accept = r_seq_ready & bus.seq_valid;

    // RAM port is driven combinationally so the read-first data returns
    // exactly one cycle after accept; idle cycles hold the previous address.
    always_comb begin
        w_bm_addr = r_last_addr;
        w_bm_we   = 1'b0;
        w_bm_din  = 1'b0;
        if (r_state == ST_CLEAR) begin
            w_bm_addr = r_sweep;
            w_bm_we   = 1'b1;
        end else if (w_accept) begin
            w_bm_addr = bus.seq_id;
            w_bm_we   = 1'b1;
            w_bm_din  = 1'b1;
        end
    end

    // FSM plus result pipeline; clr_req restarts the sweep from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_CLEAR;
            r_sweep     <= '0;
            r_last_addr <= '0;
            r_seq_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_res_valid <= 1'b0;
            r_res_seq   <= '0;
        end else begin
            r_last_addr <= w_bm_addr;
            r_res_valid <= w_accept;
            if (w_accept) begin
                r_res_seq <= bus.seq_id;
            end
            if (bus.clr_req) begin
                r_state     <= ST_CLEAR;
                r_sweep     <= '0;
                r_seq_ready <= 1'b0;
                r_busy      <= 1'b1;
            end else begin
                case (r_state)
                    ST_CLEAR: begin
                        r_sweep <= r_sweep + ADDR_W'(1);
                        if (r_sweep == LAST_ADDR) begin
                            r_state     <= ST_RUN;
                            r_seq_ready <= 1'b1;
                            r_busy      <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_RUN;
                    end
                endcase
            end
        end
    end

    assign bus.bm_addr   = w_bm_addr;
    assign bus.bm_we     = w_bm_we;
    assign bus.bm_din    = w_bm_din;
    assign bus.seq_ready = r_seq_ready;
    assign bus.busy      = r_busy;
    assign bus.res_valid = r_res_valid;
    assign bus.res_seq   = r_res_seq;
    // The old bit read back by the set is the duplicate flag.
    assign bus.res_dup   = r_res_valid & bus.bm_dout;

`ifdef RX_SEQ_STATS_EN
    logic w_inc_uniq;
    logic w_inc_dup;

    assign w_inc_uniq = r_res_valid & ~bus.bm_dout;
    assign w_inc_dup  = r_res_valid &  bus.bm_dout;

    rx_sat_counter #(.CNT_W(CNT_W)) u_uniq_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (bus.clr_req),
        .i_inc (w_inc_uniq),
        .o_cnt (bus.uniq_cnt)
    );

    rx_sat_counter #(.CNT_W(CNT_W)) u_dup_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (bus.clr_req),
        .i_inc (w_inc_dup),
        .o_cnt (bus.dup_cnt)
    );
`else
    assign bus.uniq_cnt = '0;
    assign bus.dup_cnt  = '0;
`endif

endmodule

// File: tb/tb_rx_seq_bitmap_ctrl.sv
// Bench for rx_seq_bitmap_ctrl with a behavioural read-first bitmap RAM.
// Latency: n/a.
// Backpressure: ID source waits on seq_ready.
module tb_rx_seq_bitmap_ctrl;
    // Narrow address width keeps each clear sweep short.
    localparam int AW = 12;
    localparam int CW = 32;
    localparam int N  = 1 << AW;
    localparam logic [AW-1:0] ID_MAX = {AW{1'b1}};
    localparam logic [AW-1:0] MID    = 12'h234;

    typedef struct packed {
        logic          dup;
        logic [AW-1:0] seq;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    rx_seq_bitmap_ctrl_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

    rx_seq_bitmap_ctrl #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Read-first RAM model; first edge seeds stale non-zero content.
    logic mem [0:N-1];
    bit   mem_seeded = 1'b0;
    always @(posedge clk) begin
        if (!mem_seeded) begin
            for (int i = 0; i < N; i++) mem[i] <= (i % 3 != 0);
            mem_seeded  <= 1'b1;
            bus.bm_dout <= 1'b1;
        end else begin
            bus.bm_dout <= mem[bus.bm_addr];
            if (bus.bm_we) mem[bus.bm_addr] <= bus.bm_din;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic longint exp_cnt(input longint v);
`ifdef RX_SEQ_STATS_EN
        return v;
`else
        return 0;
`endif
    endfunction

    // Offer one ID for one cycle; call at a negedge, returns at the next one.
    task automatic send(input logic [AW-1:0] id, input logic dup);
        chk("seq_ready_at_send", bus.seq_ready, 1);
        bus.seq_valid = 1'b1;
        bus.seq_id    = id;
        exp_q.push_back('{dup: dup, seq: id});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.seq_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Count consecutive busy samples, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (bus.busy && n <= N + 8) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic chk_counters(input string tag, input longint u, input longint d);
        chk({tag, "_uniq_cnt"}, bus.uniq_cnt, exp_cnt(u));
        chk({tag, "_dup_cnt"},  bus.dup_cnt,  exp_cnt(d));
    endtask

    // Scoreboard monitor: every result must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.res_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got seq 0x%0h dup %0d, expected none",
                         bus.res_seq, bus.res_dup);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("res_seq", bus.res_seq, e.seq);
                chk("res_dup", bus.res_dup, e.dup);
            end
        end
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nz;
        bus.seq_valid = 1'b0;
        bus.seq_id    = '0;
        bus.clr_req   = 1'b0;

        // 1. One-cycle reset, reset values, then a full clear sweep.
        @(posedge clk);
        @(negedge clk);
        chk("rst_seq_ready", bus.seq_ready, 0);
        chk("rst_busy",      bus.busy,      1);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_seq",   bus.res_seq,   0);
        chk("rst_res_dup",   bus.res_dup,   0);
        chk("rst_bm_we",     bus.bm_we,     1);
        chk("rst_bm_din",    bus.bm_din,    0);
        chk("rst_bm_addr",   bus.bm_addr,   0);
        chk_counters("rst", 0, 0);
        rst = 1'b0;
        count_busy(n);
        chk("init_busy_cycles", n, N);
        chk("init_seq_ready",   bus.seq_ready, 1);
        nz = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== 1'b0) nz++;
        chk("init_mem_nonzero_bits", nz, 0);

        // 2. IDs 5, 9, 5 back-to-back.
        send(AW'(5), 1'b0);
        send(AW'(9), 1'b0);
        send(AW'(5), 1'b1);
        idle(2);
        chk_counters("t2", 2, 1);

        // 3. Top address twice, then address 0.
        send(ID_MAX, 1'b0);
        send(ID_MAX, 1'b1);
        send(AW'(0), 1'b0);
        idle(2);
        chk_counters("t3", 4, 2);

        // 4. clr_req in the cycle after accepting ID 7.
        send(AW'(7), 1'b0);
        bus.seq_valid = 1'b0;
        bus.clr_req   = 1'b1;
        @(negedge clk);
        bus.clr_req   = 1'b0;
        chk_counters("t4_after_clr", 0, 0);
        chk("t4_busy", bus.busy, 1);
        count_busy(n);
        chk("t4_busy_cycles", n, N);
        send(AW'(7), 1'b0);
        idle(2);
        chk_counters("t4_post", 1, 0);

        // 5. Restart a clear mid-sweep.
        send(AW'(9), 1'b0);
        bus.seq_valid = 1'b0;
        bus.clr_req   = 1'b1;
        @(negedge clk);
        bus.clr_req   = 1'b0;
        for (int i = 0; i < N + 8 && bus.bm_addr != MID; i++) @(negedge clk);
        chk("t5_sweep_mid_addr", bus.bm_addr, MID);
        bus.clr_req = 1'b1;
        @(negedge clk);
        bus.clr_req = 1'b0;
        chk("t5_restart_addr", bus.bm_addr, 0);
        chk("t5_restart_we",   bus.bm_we,   1);
        count_busy(n);
        chk("t5_busy_cycles", n, N);
        send(AW'(9), 1'b0);
        send(AW'(9), 1'b1);
        idle(2);
        chk_counters("t5_post", 1, 1);

        idle(3);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
